// File: rtl/pokey_pkg.sv
// pokey_pkg
// Shared definitions for the audio timer controller: register addresses,
// AUDCTL bit positions, default prescaler divisors and the AUDF write decode.
package pokey_pkg;

  localparam logic [3:0] ADDR_AUDF1  = 4'h0;
  localparam logic [3:0] ADDR_AUDF2  = 4'h2;
  localparam logic [3:0] ADDR_AUDF3  = 4'h4;
  localparam logic [3:0] ADDR_AUDF4  = 4'h6;
  localparam logic [3:0] ADDR_AUDCTL = 4'h8;
  localparam logic [3:0] ADDR_STIMER = 4'h9;

  // AUDCTL bit indices (bits 1, 2 and 7 are stored and exported only)
  localparam int AC_BASE15   = 0;  // base tick from the 15 kHz prescaler
  localparam int AC_LINK34   = 3;  // channel 4 clocked by channel 3 borrow
  localparam int AC_LINK12   = 4;  // channel 2 clocked by channel 1 borrow
  localparam int AC_CH3_FAST = 5;  // channel 3 counts every machine cycle
  localparam int AC_CH1_FAST = 6;  // channel 1 counts every machine cycle

  localparam int DIV64_DEFAULT = 28;
  localparam int DIV15_DEFAULT = 114;

  // One-hot chain select for an AUDF address, zero for anything else.
  function automatic logic [3:0] audf_wr_mask(input logic [3:0] a);
    logic [3:0] mask;
    mask = 4'h0;
    case (a)
      ADDR_AUDF1: mask = 4'b0001;
      ADDR_AUDF2: mask = 4'b0010;
      ADDR_AUDF3: mask = 4'b0100;
      ADDR_AUDF4: mask = 4'b1000;
      default:    mask = 4'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pokey_prescaler.sv
// pokey_prescaler
// Two free-running machine-clock dividers producing the 64 kHz and 15 kHz
// base ticks. Each tick is registered and high for one cycle when its counter
// sits at terminal count. Only nRst restarts the dividers.
// Ports:
//   clk      in   machine clock, state changes on the falling edge
//   nRst     in   asynchronous active-low reset
//   o_tick64 out  one-cycle pulse every DIV64 cycles
//   o_tick15 out  one-cycle pulse every DIV15 cycles
module pokey_prescaler #(
  parameter int DIV64 = 28,
  parameter int DIV15 = 114
) (
  input  logic clk,
  input  logic nRst,
  output logic o_tick64,
  output logic o_tick15
);

  localparam int DIV_MAX = (DIV64 > DIV15) ? DIV64 : DIV15;
  localparam int CW      = $clog2(DIV_MAX);

  for (genvar gi = 0; gi < 2; gi++) begin : g_div
    localparam int DIV = (gi == 0) ? DIV64 : DIV15;

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_tc;

    assign w_tc = (r_cnt == CW'(DIV - 1));

    always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= w_tc ? '0 : r_cnt + 1'b1;
        r_tick <= w_tc;
      end
    end
  end

  assign o_tick64 = g_div[0].r_tick;
  assign o_tick15 = g_div[1].r_tick;

endmodule

// File: rtl/pokey_timer_ctrl.sv
// pokey_timer_ctrl
// Register decode, count-enable selection, channel linking and
// reload-on-underflow for the four external 8-bit borrow-cell counter chains.
// Ports:
//   clk     in   machine clock; all state changes on the falling edge
//   nRst    in   asynchronous active-low reset
//   addr    in   register address (AUDF1..4 = 0,2,4,6; AUDCTL = 8; STIMER = 9)
//   din     in   write data
//   we      in   write strobe
//   bor     in   borrow-out of each chain's MSB cell
//   dout    out  registered AUDF data to the chains' D inputs
//   wr      out  per-chain one-cycle write strobe
//   ld      out  per-chain one-cycle reload strobe
//   cr      out  per-chain count enable into the LSB cell
//   tmr     out  per-channel one-cycle underflow pulse
//   audctl  out  current AUDCTL value
module pokey_timer_ctrl
  import pokey_pkg::*;
#(
  parameter int DIV64 = DIV64_DEFAULT,
  parameter int DIV15 = DIV15_DEFAULT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  input  logic       we,
  input  logic [3:0] bor,
  output logic [7:0] dout,
  output logic [3:0] wr,
  output logic [3:0] ld,
  output logic [3:0] cr,
  output logic [3:0] tmr,
  output logic [7:0] audctl
);

  logic [7:0] r_dout;
  logic [3:0] r_wr;
  logic [3:0] r_ld;
  logic [3:0] r_tmr;
  logic [7:0] r_audctl;

  logic       w_tick64;
  logic       w_tick15;
  logic       w_base;
  logic       w_link12;
  logic       w_link34;
  logic [3:0] w_wr_mask;
  logic       w_audctl_we;
  logic       w_stimer_we;
  logic [3:0] w_tick;
  logic [3:0] w_reload;
  logic [3:0] w_pulse;

  pokey_prescaler #(
    .DIV64(DIV64),
    .DIV15(DIV15)
  ) u_prescaler (
    .clk      (clk),
    .nRst     (nRst),
    .o_tick64 (w_tick64),
    .o_tick15 (w_tick15)
  );

  assign w_wr_mask   = we ? audf_wr_mask(addr) : 4'h0;
  assign w_audctl_we = we && (addr == ADDR_AUDCTL);
  assign w_stimer_we = we && (addr == ADDR_STIMER);

  assign w_link12 = r_audctl[AC_LINK12];
  assign w_link34 = r_audctl[AC_LINK34];
  assign w_base   = r_audctl[AC_BASE15] ? w_tick15 : w_tick64;

  // Linked high channels count on the low channel's borrow, which makes
  // bor -> cr a deliberate combinational ripple through this block.
  assign w_tick[0] = r_audctl[AC_CH1_FAST] | w_base;
  assign w_tick[1] = w_link12 ? bor[0] : w_base;
  assign w_tick[2] = r_audctl[AC_CH3_FAST] | w_base;
  assign w_tick[3] = w_link34 ? bor[2] : w_base;

  // A linked low chain free-wraps on its own borrow and is reloaded only
  // together with its high partner; only the high channel raises tmr.
  assign w_reload = {bor[3], (w_link34 ? bor[3] : bor[2]),
                     bor[1], (w_link12 ? bor[1] : bor[0])};
  assign w_pulse  = {bor[3], bor[2] & ~w_link34,
                     bor[1], bor[0] & ~w_link12};

  // The reload cycle must not also decrement, so ld gates the count enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cr
    assign cr[gi] = w_tick[gi] & ~r_ld[gi];
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      r_dout   <= 8'h00;
      r_wr     <= 4'h0;
      r_ld     <= 4'h0;
      r_tmr    <= 4'h0;
      r_audctl <= 8'h00;
    end else begin
      r_wr <= w_wr_mask;
      if (|w_wr_mask) begin
        r_dout <= din;
      end
      if (w_audctl_we) begin
        r_audctl <= din;
      end
      // STIMER and an underflow on the same edge merge into one ld.
      r_ld  <= w_reload | {4{w_stimer_we}};
      r_tmr <= w_pulse;
    end
  end

  assign dout   = r_dout;
  assign wr     = r_wr;
  assign ld     = r_ld;
  assign tmr    = r_tmr;
  assign audctl = r_audctl;

endmodule

// File: tb/tb_pokey_timer_ctrl.sv
// tb_pokey_timer_ctrl
// Bench for pokey_timer_ctrl. Four behavioural 8-bit borrow chains close the
// loop around the controller; expected periods and strobes come from the
// timing rules (N+2, (N+1)*DIV, V+2, one-cycle strobes) computed here.
module tb_pokey_timer_ctrl;

  localparam int DIV64 = 28;
  localparam int DIV15 = 114;
  localparam logic [3:0] AUDCTL_A = 4'h8;
  localparam logic [3:0] STIMER_A = 4'h9;

  logic       clk;
  logic       nRst;
  logic [3:0] addr;
  logic [7:0] din;
  logic       we;
  logic [3:0] bor;
  logic [7:0] dout;
  logic [3:0] wr;
  logic [3:0] ld;
  logic [3:0] cr;
  logic [3:0] tmr;
  logic [7:0] audctl;

  int checks;
  int errors;
  int stamps[$];
  int silent_hits;
  int ld_mis;
  int pair_mis;

  pokey_timer_ctrl #(
    .DIV64(DIV64),
    .DIV15(DIV15)
  ) dut (
    .clk    (clk),
    .nRst   (nRst),
    .addr   (addr),
    .din    (din),
    .we     (we),
    .bor    (bor),
    .dout   (dout),
    .wr     (wr),
    .ld     (ld),
    .cr     (cr),
    .tmr    (tmr),
    .audctl (audctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter chains: WR and Ld resolve on the same edge, Ld taking the fresh D.
  logic [7:0] ch_cnt   [4];
  logic [7:0] ch_latch [4];

  always @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 4; i++) begin
        ch_cnt[i]   <= 8'h00;
        ch_latch[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr[i]) ch_latch[i] <= dout;
        if (ld[i]) ch_cnt[i] <= wr[i] ? dout : ch_latch[i];
        else if (cr[i]) ch_cnt[i] <= ch_cnt[i] - 8'd1;
      end
    end
  end

  always_comb begin
    bor = 4'h0;
    for (int i = 0; i < 4; i++) bor[i] = cr[i] & (ch_cnt[i] == 8'h00);
  end

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    we   = 1'b0;
  endtask

  // Record sample indices of tmr[ch] pulses plus side observations.
  task automatic collect(input int ch, input int npulse, input int budget,
                         input logic [3:0] silent, input int pair);
    stamps.delete();
    silent_hits = 0;
    ld_mis      = 0;
    pair_mis    = 0;
    for (int c = 0; c < budget && stamps.size() < npulse; c++) begin
      @(posedge clk);
      if (tmr[ch] === 1'b1) stamps.push_back(c);
      if ((tmr & silent) !== 4'h0) silent_hits++;
      if (ld[ch] !== tmr[ch]) ld_mis++;
      if (pair >= 0 && ld[pair] !== ld[ch]) pair_mis++;
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      addr = 4'($urandom_range(0, 15));
      din  = 8'($urandom);
      we   = ~we;
      @(posedge clk);
      checks++;
      if ({dout, wr, ld, cr, tmr, audctl} !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold outputs got %h want 0", {dout, wr, ld, cr, tmr, audctl});
      end
    end
    we   = 1'b0;
    nRst = 1'b1;
    for (int k = 1; k <= DIV64; k++) begin
      @(posedge clk);
      checks++;
      if (cr !== ((k == DIV64) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL first_tick64 edge %0d cr got %h want %h", k, cr,
                 (k == DIV64) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_write_decode();
    logic [7:0] d;
    logic [7:0] last_d;
    logic [7:0] ac;
    logic [3:0] ign;
    int         n;
    last_d = 8'h00;
    // back-to-back AUDF writes on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 3);
      d = 8'($urandom);
      bus_write(4'(2 * n), d);
      last_d = d;
      checks++;
      if (wr !== 4'(1 << n)) begin
        errors++;
        $display("FAIL audf_wr ch %0d got %b want %b", n + 1, wr, 4'(1 << n));
      end
      checks++;
      if (dout !== d) begin
        errors++;
        $display("FAIL audf_dout got %h want %h", dout, d);
      end
    end
    @(posedge clk);
    checks++;
    if (wr !== 4'h0) begin
      errors++;
      $display("FAIL wr_one_cycle got %b want 0000", wr);
    end
    ac = 8'($urandom);
    bus_write(AUDCTL_A, ac);
    checks++;
    if (audctl !== ac) begin
      errors++;
      $display("FAIL audctl_write got %h want %h", audctl, ac);
    end
    for (int i = 0; i < 4; i++) begin
      ign = (i % 2 == 1) ? 4'(2 * $urandom_range(0, 3) + 1) : 4'($urandom_range(10, 15));
      bus_write(ign, 8'($urandom));
      checks++;
      if (wr !== 4'h0 || dout !== last_d || audctl !== ac) begin
        errors++;
        $display("FAIL ignored_addr %h wr %b dout %h audctl %h want 0000 %h %h",
                 ign, wr, dout, audctl, last_d, ac);
      end
    end
    bus_write(STIMER_A, 8'($urandom));
    checks++;
    if (ld !== 4'hF || wr !== 4'h0 || dout !== last_d) begin
      errors++;
      $display("FAIL stimer_ld ld %h wr %b dout %h want F 0000 %h", ld, wr, dout, last_d);
    end
  endtask

  task automatic test_fast();
    int         n;
    int         ch;
    logic [7:0] ac;
    for (int it = 0; it < 4; it++) begin
      ch = (it % 2 == 0) ? 0 : 2;
      ac = (ch == 0) ? 8'h40 : 8'h20;
      n  = (it == 0) ? 3 : $urandom_range(0, 40);
      bus_write(AUDCTL_A, ac);
      bus_write(4'(2 * ch), 8'(n));
      bus_write(STIMER_A, 8'($urandom));
      repeat (2) @(posedge clk);
      collect(ch, 4, 4 * (n + 2) + 8, 4'h0, -1);
      checks++;
      if (stamps.size() != 4) begin
        errors++;
        $display("FAIL fast_pulses ch %0d N %0d got %0d want 4", ch + 1, n, stamps.size());
      end else begin
        for (int i = 1; i < 4; i++) begin
          checks++;
          if (stamps[i] - stamps[i-1] != n + 2) begin
            errors++;
            $display("FAIL fast_period ch %0d N %0d got %0d want %0d", ch + 1, n,
                     stamps[i] - stamps[i-1], n + 2);
          end
        end
      end
      checks++;
      if (ld_mis != 0) begin
        errors++;
        $display("FAIL fast_ld_tmr ch %0d mismatching cycles got %0d want 0", ch + 1, ld_mis);
      end
    end
  endtask

  task automatic test_base_rate();
    int         n;
    int         ch;
    int         div;
    int         exp_p;
    logic [7:0] ac;
    for (int it = 0; it < 4; it++) begin
      if (it < 2) begin
        ch = 1;
        n  = 1;
        ac = 8'(it);
      end else begin
        ch = $urandom_range(0, 3);
        n  = $urandom_range(0, 2);
        ac = 8'($urandom_range(0, 1));
      end
      div   = ac[0] ? DIV15 : DIV64;
      exp_p = (n + 1) * div;
      bus_write(AUDCTL_A, ac);
      bus_write(4'(2 * ch), 8'(n));
      bus_write(STIMER_A, 8'h00);
      repeat (2) @(posedge clk);
      collect(ch, 3, 4 * exp_p + 20, 4'h0, -1);
      checks++;
      if (stamps.size() != 3) begin
        errors++;
        $display("FAIL base_pulses ch %0d got %0d want 3", ch + 1, stamps.size());
      end else begin
        for (int i = 1; i < 3; i++) begin
          checks++;
          if (stamps[i] - stamps[i-1] != exp_p) begin
            errors++;
            $display("FAIL base_period ch %0d audctl %h N %0d got %0d want %0d", ch + 1, ac, n,
                     stamps[i] - stamps[i-1], exp_p);
          end
        end
      end
    end
  endtask

  task automatic test_linked();
    int         lo;
    int         hi;
    int         hich;
    int         exp_p;
    logic [7:0] ac;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        ac = 8'h50; lo = 0; hi = 1;
      end else begin
        ac = (it == 1) ? 8'h28 : 8'h50;
        lo = $urandom_range(0, 255);
        hi = $urandom_range(0, 1);
      end
      hich  = (ac == 8'h50) ? 1 : 3;
      exp_p = hi * 256 + lo + 2;
      bus_write(AUDCTL_A, ac);
      bus_write(4'(2 * (hich - 1)), 8'(lo));
      bus_write(4'(2 * hich), 8'(hi));
      bus_write(STIMER_A, 8'h00);
      repeat (2) @(posedge clk);
      collect(hich, 3, 3 * exp_p + 20, 4'(1 << (hich - 1)), hich - 1);
      checks++;
      if (stamps.size() != 3) begin
        errors++;
        $display("FAIL linked_pulses ch %0d got %0d want 3", hich + 1, stamps.size());
      end else begin
        for (int i = 1; i < 3; i++) begin
          checks++;
          if (stamps[i] - stamps[i-1] != exp_p) begin
            errors++;
            $display("FAIL linked_period ch %0d V %0d got %0d want %0d", hich + 1,
                     hi * 256 + lo, stamps[i] - stamps[i-1], exp_p);
          end
        end
      end
      checks++;
      if (silent_hits != 0) begin
        errors++;
        $display("FAIL linked_low_tmr ch %0d pulses got %0d want 0", hich, silent_hits);
      end
      checks++;
      if (pair_mis != 0 || ld_mis != 0) begin
        errors++;
        $display("FAIL linked_ld pair mismatches %0d ld/tmr mismatches %0d want 0 0",
                 pair_mis, ld_mis);
      end
    end
  endtask

  task automatic test_coincident();
    bit found;
    bus_write(AUDCTL_A, 8'h40);
    bus_write(4'h0, 8'd5);
    bus_write(STIMER_A, 8'h00);
    // AUDF write landing on the underflow edge
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (bor[0] === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL audf_uf_wait got no underflow want one within 20 cycles");
    end else begin
      bus_write(4'h0, 8'd2);
      checks++;
      if ({wr[0], ld[0], tmr[0]} !== 3'b111) begin
        errors++;
        $display("FAIL audf_uf_strobes wr/ld/tmr got %b want 111", {wr[0], ld[0], tmr[0]});
      end
      collect(0, 1, 20, 4'h0, -1);
      checks++;
      if (stamps.size() != 1 || stamps[0] != 3) begin
        errors++;
        $display("FAIL audf_uf_period got %0d want 4", (stamps.size() == 1) ? stamps[0] + 1 : -1);
      end
    end
    // STIMER landing on the underflow edge
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (bor[0] === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stimer_uf_wait got no underflow want one within 20 cycles");
    end else begin
      bus_write(STIMER_A, 8'($urandom));
      checks++;
      if (ld !== 4'hF || tmr[0] !== 1'b1) begin
        errors++;
        $display("FAIL stimer_uf ld %h tmr0 %b want F 1", ld, tmr[0]);
      end
    end
    // STIMER mid-count restarts without a pulse
    bus_write(4'h0, 8'd40);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      if (tmr[0] === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stimer_mid_wait got no pulse want one within 60 cycles");
    end else begin
      repeat (10) @(posedge clk);
      bus_write(STIMER_A, 8'($urandom));
      checks++;
      if (ld[0] !== 1'b1 || tmr[0] !== 1'b0) begin
        errors++;
        $display("FAIL stimer_mid ld0 %b tmr0 %b want 1 0", ld[0], tmr[0]);
      end
      collect(0, 1, 60, 4'h0, -1);
      checks++;
      if (stamps.size() != 1 || stamps[0] != 41) begin
        errors++;
        $display("FAIL stimer_restart first pulse after ld got %0d want 42",
                 (stamps.size() == 1) ? stamps[0] + 1 : -1);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    int         n;
    n = $urandom_range(10, 50);
    bus_write(AUDCTL_A, 8'h40);
    bus_write(4'h0, 8'(n));
    bus_write(STIMER_A, 8'h00);
    repeat ($urandom_range(5, 40)) @(posedge clk);
    d = 8'($urandom_range(1, 255));
    bus_write(4'h2, d);
    #($urandom_range(1, 3));
    nRst = 1'b0;
    #1;
    checks++;
    if (wr !== 4'h0 || ld !== 4'h0 || tmr !== 4'h0) begin
      errors++;
      $display("FAIL async_rst_strobes wr %b ld %b tmr %b want 0", wr, ld, tmr);
    end
    checks++;
    if (cr !== 4'h0) begin
      errors++;
      $display("FAIL async_rst_cr got %b want 0000", cr);
    end
    checks++;
    if (audctl !== 8'h00 || dout !== 8'h00) begin
      errors++;
      $display("FAIL async_rst_regs audctl %h dout %h want 00 00", audctl, dout);
    end
    repeat (2) @(posedge clk);
    nRst = 1'b1;
    bus_write(AUDCTL_A, 8'h5A);
    checks++;
    if (audctl !== 8'h5A) begin
      errors++;
      $display("FAIL post_release_write audctl got %h want 5a", audctl);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRst   = 1'b0;
    we     = 1'b0;
    addr   = 4'h0;
    din    = 8'h00;
    test_reset();
    test_write_decode();
    test_fast();
    test_base_rate();
    test_linked();
    test_coincident();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
